// File: rtl/mem_unit.sv
// Memory-side responder: holds the MAR and turns byte or word requests into one or
// two 8-bit external bus transfers. The pipeline is stalled through stop until the access completes.
module mem_unit #(
  parameter int unsigned BUS_TIMEOUT = 0,
  parameter logic [15:0] MAR_RESET   = 16'h0000
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        mar_wr,
  input  logic [15:0] addr_in,
  input  logic        mem_rq,
  input  logic        mem_rq_cmd,
  input  logic        mem_rq_width,
  input  logic [15:0] wdata,
  output logic        stop,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic        bus_ready
);

  localparam int unsigned CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = (BUS_TIMEOUT == 0) ? '0 : CW'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        state, state_nx;
  logic [15:0]   mar;
  logic [15:0]   acc_addr;
  logic [15:0]   wdata_q;
  logic          cmd_q;
  logic          width_q;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          abort;
  logic          timeout_hit;

  assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt == TO_LAST);

  // Every output below depends only on registered state, so nothing the requester
  // gates with stop can loop back into stop.
  always_comb begin
    state_nx    = state;
    stop        = 1'b0;
    bus_rd      = 1'b0;
    bus_wr      = 1'b0;
    bus_addr    = mar;
    bus_dout    = '0;
    rdata_valid = 1'b0;
    accept      = 1'b0;
    abort       = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_rq) begin
          accept   = 1'b1;
          state_nx = LO;
        end
      end
      LO: begin
        stop     = 1'b1;
        bus_addr = acc_addr;
        bus_rd   = ~cmd_q;
        bus_wr   = cmd_q;
        bus_dout = wdata_q[7:0];
        if (bus_ready) begin
          state_nx = width_q ? HI : DONE;
        end else if (timeout_hit) begin
          abort    = 1'b1;
          state_nx = DONE;
        end
      end
      HI: begin
        stop     = 1'b1;
        bus_addr = acc_addr + 16'd1;
        bus_rd   = ~cmd_q;
        bus_wr   = cmd_q;
        bus_dout = wdata_q[15:8];
        if (bus_ready) begin
          state_nx = DONE;
        end else if (timeout_hit) begin
          abort    = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        rdata_valid = 1'b1;
        if (mem_rq) begin
          accept   = 1'b1;
          state_nx = LO;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      mar      <= MAR_RESET;
      acc_addr <= MAR_RESET;
      wdata_q  <= '0;
      cmd_q    <= 1'b0;
      width_q  <= 1'b0;
      rdata    <= '0;
      bus_err  <= 1'b0;
      cnt      <= '0;
    end else begin
      bus_err <= abort;
      if (mar_wr && ((state == IDLE) || (state == DONE))) begin
        mar <= addr_in;
      end
      // A same-cycle MAR load bypasses straight into the access address.
      if (accept) begin
        acc_addr <= mar_wr ? addr_in : mar;
        cmd_q    <= mem_rq_cmd;
        width_q  <= mem_rq_width;
        wdata_q  <= wdata;
      end
      if (abort) begin
        rdata <= '1;
      end else if (bus_ready && !cmd_q) begin
        if (state == LO) begin
          rdata <= width_q ? {rdata[15:8], bus_din} : {8'h00, bus_din};
        end else if (state == HI) begin
          rdata[15:8] <= bus_din;
        end
      end
      // LO->HI only happens on a ready cycle, so clearing on ready covers entry to HI.
      if ((BUS_TIMEOUT != 0) && stop && !bus_ready) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: expected completions are queued at request time
// and popped when rdata_valid appears; bus phases are checked cycle by cycle.
module tb_mem_unit;

  logic        clk;
  logic        a_rst;
  logic        mar_wr;
  logic [15:0] addr_in;
  logic        mem_rq;
  logic        mem_rq_cmd;
  logic        mem_rq_width;
  logic [15:0] wdata;
  logic        stop;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        bus_err;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_ready;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  int   stopcnt;
  int   vcnt;

  mem_unit #(
    .BUS_TIMEOUT(3),
    .MAR_RESET  (16'hA5A0)
  ) dut (
    .clk         (clk),
    .a_rst       (a_rst),
    .mar_wr      (mar_wr),
    .addr_in     (addr_in),
    .mem_rq      (mem_rq),
    .mem_rq_cmd  (mem_rq_cmd),
    .mem_rq_width(mem_rq_width),
    .wdata       (wdata),
    .stop        (stop),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .bus_err     (bus_err),
    .bus_addr    (bus_addr),
    .bus_dout    (bus_dout),
    .bus_din     (bus_din),
    .bus_rd      (bus_rd),
    .bus_wr      (bus_wr),
    .bus_ready   (bus_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] r, input logic e);
    exp_t t;
    t.rdata = r;
    t.err   = e;
    sb.push_back(t);
  endtask

  task automatic sb_pop(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'b0, rdata_valid}, 32'd1);
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, {16'b0, rdata}, {16'b0, e.rdata});
      chk({tag, "_err"}, {31'b0, bus_err}, {31'b0, e.err});
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    a_rst = 1'b0; mar_wr = 1'b0; addr_in = '0; mem_rq = 1'b0;
    mem_rq_cmd = 1'b0; mem_rq_width = 1'b0; wdata = '0;
    bus_din = '0; bus_ready = 1'b0;
    tick(); tick();

    chk("rst_stop", stop, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", rdata_valid, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_rd", bus_rd, 0);
    chk("rst_wr", bus_wr, 0);
    chk("rst_addr", bus_addr, 16'hA5A0);
    chk("rst_dout", bus_dout, 0);
    a_rst = 1'b1;
    tick();
    chk("idle_addr", bus_addr, 16'hA5A0);

    // byte read at 0x1234
    mar_wr = 1'b1; addr_in = 16'h1234;
    tick();
    mar_wr = 1'b0; addr_in = '0;
    chk("t1_mar", bus_addr, 16'h1234);
    mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0;
    bus_din = 8'hAB; bus_ready = 1'b1;
    push(16'h00AB, 1'b0);
    tick();
    mem_rq = 1'b0;
    chk("t1_c1_stop", stop, 1);
    chk("t1_c1_addr", bus_addr, 16'h1234);
    chk("t1_c1_rd", bus_rd, 1);
    chk("t1_c1_wr", bus_wr, 0);
    chk("t1_c1_valid", rdata_valid, 0);
    tick();
    sb_pop("t1");
    chk("t1_c2_stop", stop, 0);
    chk("t1_c2_rd", bus_rd, 0);
    tick();
    chk("t1_c3_valid", rdata_valid, 0);
    chk("t1_hold", rdata, 16'h00AB);

    // word write with MAR bypass at 0xFFFF
    mar_wr = 1'b1; addr_in = 16'hFFFF; mem_rq = 1'b1;
    mem_rq_cmd = 1'b1; mem_rq_width = 1'b1; wdata = 16'hBEEF; bus_ready = 1'b1;
    push(16'h00AB, 1'b0);
    tick();
    mar_wr = 1'b0; mem_rq = 1'b0; addr_in = '0; wdata = '0;
    chk("t2_lo_addr", bus_addr, 16'hFFFF);
    chk("t2_lo_dout", bus_dout, 8'hEF);
    chk("t2_lo_wr", bus_wr, 1);
    chk("t2_lo_rd", bus_rd, 0);
    chk("t2_lo_stop", stop, 1);
    tick();
    chk("t2_hi_addr", bus_addr, 16'h0000);
    chk("t2_hi_dout", bus_dout, 8'hBE);
    chk("t2_hi_wr", bus_wr, 1);
    chk("t2_hi_stop", stop, 1);
    tick();
    sb_pop("t2");
    chk("t2_done_wr", bus_wr, 0);
    tick();
    chk("t2_mar", bus_addr, 16'hFFFF);
    chk("t2_idle_dout", bus_dout, 0);

    // word read with two wait states in LO
    mar_wr = 1'b1; addr_in = 16'h2000;
    tick();
    mar_wr = 1'b0;
    mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b1;
    bus_ready = 1'b0; bus_din = 8'h00;
    push(16'h5511, 1'b0);
    stopcnt = 0;
    tick();
    mem_rq = 1'b0;
    stopcnt += int'(stop);
    chk("t3_w1_addr", bus_addr, 16'h2000);
    tick();
    stopcnt += int'(stop);
    chk("t3_w2_addr", bus_addr, 16'h2000);
    chk("t3_w2_rd", bus_rd, 1);
    tick();
    stopcnt += int'(stop);
    chk("t3_lo_addr", bus_addr, 16'h2000);
    bus_ready = 1'b1; bus_din = 8'h11;
    tick();
    stopcnt += int'(stop);
    chk("t3_hi_addr", bus_addr, 16'h2001);
    bus_din = 8'h55;
    tick();
    stopcnt += int'(stop);
    sb_pop("t3");
    chk("t3_stopcnt", stopcnt, 4);

    // timeout abort after three not-ready cycles
    mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b1; bus_ready = 1'b0;
    push(16'hFFFF, 1'b1);
    tick();
    mem_rq = 1'b0;
    tick();
    tick();
    chk("t4_c3_err", bus_err, 0);
    chk("t4_c3_valid", rdata_valid, 0);
    chk("t4_c3_stop", stop, 1);
    tick();
    sb_pop("t4");
    chk("t4_c4_stop", stop, 0);
    tick();
    chk("t4_c5_valid", rdata_valid, 0);
    chk("t4_c5_err", bus_err, 0);
    chk("t4_c5_stop", stop, 0);
    chk("t4_c5_idle", bus_addr, 16'h2000);
    chk("t4_hold", rdata, 16'hFFFF);

    // back-to-back byte reads, MAR write during LO is ignored
    bus_ready = 1'b1; mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0;
    bus_din = 8'h3C;
    push(16'h003C, 1'b0);
    tick();
    mem_rq = 1'b0;
    chk("t5_c1_stop", stop, 1);
    mar_wr = 1'b1; addr_in = 16'hDEAD;
    tick();
    mar_wr = 1'b0; addr_in = '0;
    sb_pop("t5a");
    mem_rq = 1'b1; bus_din = 8'hC3;
    push(16'h00C3, 1'b0);
    tick();
    mem_rq = 1'b0;
    chk("t5_c3_stop", stop, 1);
    chk("t5_c3_rd", bus_rd, 1);
    chk("t5_c3_addr", bus_addr, 16'h2000);
    tick();
    sb_pop("t5b");
    tick();
    chk("t5_c5_valid", rdata_valid, 0);
    chk("t5_c5_mar", bus_addr, 16'h2000);

    // reset asserted during HI of a word write
    mem_rq = 1'b1; mem_rq_cmd = 1'b1; mem_rq_width = 1'b1;
    wdata = 16'h1357; bus_ready = 1'b1;
    tick();
    mem_rq = 1'b0;
    chk("t6_lo_dout", bus_dout, 8'h57);
    tick();
    chk("t6_hi_wr", bus_wr, 1);
    chk("t6_hi_dout", bus_dout, 8'h13);
    chk("t6_hi_stop", stop, 1);
    #2 a_rst = 1'b0;
    #1;
    chk("t6_rst_wr", bus_wr, 0);
    chk("t6_rst_stop", stop, 0);
    chk("t6_rst_addr", bus_addr, 16'hA5A0);
    chk("t6_rst_rdata", rdata, 0);
    tick();
    a_rst = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vcnt += int'(rdata_valid);
      chk("t6_post_stop", stop, 0);
    end
    chk("t6_no_valid", vcnt, 0);
    chk("t6_mar", bus_addr, 16'hA5A0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
